// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types, constants and helpers for the motor command ramp
//
// Purpose: FSM state encoding, full-scale duty constant and the saturating
// magnitude helper used to turn a signed speed command into a duty target.
// Ports: none (package).

package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam int DEF_COUNTER_W = 12;

  // All-ones duty value for a w-bit PWM counter.
  function automatic logic [31:0] duty_max(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [31:0] DUTY_MAX = duty_max(DEF_COUNTER_W);

  // |v| clamped to the w-bit duty range; the most negative command has a
  // magnitude one larger than full scale and lands on full scale.
  function automatic logic [31:0] sat_abs(input logic signed [31:0] v, input int w);
    logic [31:0] mag;
    logic [31:0] lim;
    lim = duty_max(w);
    mag = v[31] ? (~v + 32'd1) : v;
    return (mag > lim) ? lim : mag;
  endfunction

endpackage

// File: rtl/ramp_tick.sv
// rtl/ramp_tick.sv - ramp prescaler producing one tick every DIV clocks
//
// Purpose: free-running 0..DIV-1 counter with synchronous clear; tick_o is
// high for the cycle in which the count equals DIV-1.
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset
//   clr_i   in   synchronous clear (count forced back to 0)
//   tick_o  out  ramp tick strobe

module ramp_tick #(
  parameter int DIV = 2500
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/motor_cmd_ramp.sv
// rtl/motor_cmd_ramp.sv - slew-rate limiter and direction sequencer ahead of the PWM stage
//
// Purpose: accepts signed speed commands over valid/ready, ramps the duty
// magnitude in STEP increments once per RAMP_DIV clocks, and routes every
// direction reversal through zero duty plus DEAD_CYCLES clocks with the
// driver disabled. Optional command watchdog: MOTOR_CMD_WATCHDOG_EN.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-low reset
//   cmd         in   signed speed command (>=0 CW, <0 CCW)
//   cmd_valid   in   cmd valid
//   cmd_ready   out  command accepted when valid && ready
//   enable_in   in   master run enable; low stops immediately
//   duty_cycle  out  PWM duty
//   direction   out  PWM direction (0 CW, 1 CCW)
//   enable_out  out  PWM enable
//   busy        out  duty not yet at target, or in dead-time
//   wdog_trip   out  sticky watchdog trip (only with MOTOR_CMD_WATCHDOG_EN)

module motor_cmd_ramp
  import motor_pkg::*;
#(
  parameter int COUNTER_W   = DEF_COUNTER_W,
  parameter int STEP        = 64,
  parameter int RAMP_DIV    = 2500,
  parameter int DEAD_CYCLES = 50000,
  parameter int TIMEOUT     = 5_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COUNTER_W:0]   cmd,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 enable_in,
  output logic [COUNTER_W-1:0] duty_cycle,
  output logic                 direction,
  output logic                 enable_out,
`ifdef MOTOR_CMD_WATCHDOG_EN
  output logic                 busy,
  output logic                 wdog_trip
`else
  output logic                 busy
`endif
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
  localparam logic [COUNTER_W:0] STEP_W = STEP[COUNTER_W:0];

  state_t               state_q, state_d;
  logic [COUNTER_W-1:0] duty_q, duty_d;
  logic                 dir_q, dir_d;
  logic [COUNTER_W-1:0] tgt_mag_q, tgt_mag_d;
  logic                 tgt_dir_q, tgt_dir_d;
  logic [DW-1:0]        dead_cnt_q, dead_cnt_d;
  logic                 en_q, rdy_q, busy_q, busy_d;
  logic                 tick;
  logic                 accept;
  logic                 wd_fire;

  logic signed [31:0]   cmd_ext;
  logic [31:0]          abs_full;
  logic [COUNTER_W-1:0] cmd_mag;
  logic [31:0]          unused_abs;

  assign accept   = cmd_valid && rdy_q && enable_in;
  assign cmd_ext  = {{(31 - COUNTER_W){cmd[COUNTER_W]}}, cmd};
  assign abs_full = sat_abs(cmd_ext, COUNTER_W);
  assign cmd_mag  = abs_full[COUNTER_W-1:0];
  assign unused_abs = abs_full;

  // Prescaler only runs in RUN, so every entry into RUN (from IDLE or from
  // the end of dead-time) waits a full RAMP_DIV before the first step.
  ramp_tick #(
    .DIV (RAMP_DIV)
  ) u_tick (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (state_q != RUN),
    .tick_o (tick)
  );

  // Step arithmetic one bit wider than duty so carry/borrow is visible.
  logic [COUNTER_W:0]   up_sum, dn_diff;
  logic [COUNTER_W-1:0] duty_up, duty_dn, floor_mag, duty_step;
  logic                 reversing;

  assign reversing = (tgt_dir_q != dir_q);
  assign up_sum    = {1'b0, duty_q} + STEP_W;
  assign dn_diff   = {1'b0, duty_q} - STEP_W;
  assign duty_up   = (up_sum > {1'b0, tgt_mag_q}) ? tgt_mag_q : up_sum[COUNTER_W-1:0];
  assign floor_mag = reversing ? '0 : tgt_mag_q;
  assign duty_dn   = (dn_diff[COUNTER_W] || (dn_diff[COUNTER_W-1:0] < floor_mag))
                   ? floor_mag : dn_diff[COUNTER_W-1:0];

  always_comb begin
    duty_step = duty_q;
    if (reversing || (duty_q > tgt_mag_q)) begin
      duty_step = duty_dn;
    end else if (duty_q < tgt_mag_q) begin
      duty_step = duty_up;
    end
  end

`ifdef MOTOR_CMD_WATCHDOG_EN
  localparam logic [31:0] TIMEOUT32 = 32'(TIMEOUT);

  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        wd_trip_q, wd_trip_d;

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    wd_trip_d = wd_trip_q;
    wd_fire   = 1'b0;
    if (accept) begin
      wd_cnt_d  = '0;
      wd_trip_d = 1'b0;
    end else if ((state_q == RUN) && (wd_cnt_q != TIMEOUT32)) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
      if (wd_cnt_d == TIMEOUT32) begin
        wd_fire   = 1'b1;
        wd_trip_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q  <= '0;
      wd_trip_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      wd_trip_q <= wd_trip_d;
    end
  end

  assign wdog_trip = wd_trip_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    dir_d      = dir_q;
    tgt_mag_d  = tgt_mag_q;
    tgt_dir_d  = tgt_dir_q;
    dead_cnt_d = dead_cnt_q;

    if (accept) begin
      tgt_mag_d = cmd_mag;
      tgt_dir_d = cmd[COUNTER_W];
    end else if (wd_fire) begin
      // Keep the current direction so a stale timeout never adds a reversal.
      tgt_mag_d = '0;
      tgt_dir_d = dir_q;
    end

    case (state_q)
      IDLE: begin
        duty_d     = '0;
        dead_cnt_d = '0;
        if (accept && (cmd_mag != '0)) begin
          state_d = RUN;
          dir_d   = cmd[COUNTER_W];
        end
      end
      RUN: begin
        // Step and exit checks see the target as it was before any accept
        // on this same edge.
        if (tick) begin
          duty_d = duty_step;
        end
        if (reversing && (duty_q == '0)) begin
          state_d    = DEAD;
          dead_cnt_d = '0;
        end else if ((tgt_mag_q == '0) && (duty_q == '0)) begin
          state_d = IDLE;
        end
      end
      DEAD: begin
        duty_d = '0;
        if (dead_cnt_q == DEAD_LAST) begin
          dir_d      = tgt_dir_q;
          dead_cnt_d = '0;
          state_d    = (tgt_mag_q == '0) ? IDLE : RUN;
        end else begin
          dead_cnt_d = dead_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
      end
    endcase

    if (!enable_in) begin
      state_d    = IDLE;
      duty_d     = '0;
      tgt_mag_d  = '0;
      tgt_dir_d  = 1'b0;
      dead_cnt_d = '0;
    end
  end

  // Busy also covers a pending reversal at equal magnitude: duty nonzero in
  // the wrong direction is not yet at the signed target.
  always_comb begin
    busy_d = (state_d == DEAD) || (duty_d != tgt_mag_d) ||
             ((duty_d != '0) && (dir_d != tgt_dir_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      duty_q     <= '0;
      dir_q      <= 1'b0;
      tgt_mag_q  <= '0;
      tgt_dir_q  <= 1'b0;
      dead_cnt_q <= '0;
      en_q       <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
      tgt_mag_q  <= tgt_mag_d;
      tgt_dir_q  <= tgt_dir_d;
      dead_cnt_q <= dead_cnt_d;
      en_q       <= (state_d == RUN);
      rdy_q      <= (state_d != DEAD);
      busy_q     <= busy_d;
    end
  end

  assign duty_cycle = duty_q;
  assign direction  = dir_q;
  assign enable_out = en_q;
  assign cmd_ready  = rdy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// tb/tb_motor_cmd_ramp.sv - directed self-checking bench for motor_cmd_ramp

module tb_motor_cmd_ramp;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [CW:0]   cmd = '0;
  logic          cmd_valid = 1'b0;
  logic          enable_in = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] duty_cycle;
  logic          direction;
  logic          enable_out;
  logic          busy;
`ifdef MOTOR_CMD_WATCHDOG_EN
  logic          wdog_trip;
`endif

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  motor_cmd_ramp #(
    .COUNTER_W   (CW),
    .STEP        (64),
    .RAMP_DIV    (4),
    .DEAD_CYCLES (8),
    .TIMEOUT     (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .enable_in  (enable_in),
    .duty_cycle (duty_cycle),
    .direction  (direction),
    .enable_out (enable_out),
`ifdef MOTOR_CMD_WATCHDOG_EN
    .busy       (busy),
    .wdog_trip  (wdog_trip)
`else
    .busy       (busy)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int low;
    int n;
    int e;

    // Reset held for 5 clocks
    repeat (5) @(negedge clk);
    chk("rst_duty", int'(duty_cycle), 0);
    chk("rst_dir", int'(direction), 0);
    chk("rst_en", int'(enable_out), 0);
    chk("rst_rdy", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b1;
    #1 chk("rdy_at_release", int'(cmd_ready), 0);
    @(negedge clk);
    chk("rdy_after_release", int'(cmd_ready), 1);

    // A zero command leaves the block idle
    enable_in = 1'b1;
    cmd = '0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("zero_cmd_en", int'(enable_out), 0);
    chk("zero_cmd_busy", int'(busy), 0);

    // Ramp up to +1024: 64 per 4 clocks, 16 ticks
    cmd = 13'd1024;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("up_en", int'(enable_out), 1);
    chk("up_dir", int'(direction), 0);
    chk("up_duty0", int'(duty_cycle), 0);
    chk("up_busy", int'(busy), 1);
    for (int k = 1; k <= 16; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("up_duty_%0d", k), int'(duty_cycle), 64 * k);
    end
    chk("up_busy_done", int'(busy), 0);

    // Reversal to -512; prescaler keeps its phase, first step 4 clocks out
    cmd = 13'h1E00;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rev_hold", int'(duty_cycle), 1024);
    chk("rev_busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    chk("rev_down_1", int'(duty_cycle), 960);
    for (int k = 2; k <= 16; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("rev_down_%0d", k), int'(duty_cycle), 1024 - 64 * k);
    end
    chk("rev_dir_before_dead", int'(direction), 0);
    low = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (!enable_out && !cmd_ready && duty_cycle == 0) low++;
      else if (low > 0) break;
    end
    chk("dead_len", low, 8);
    chk("dead_exit_en", int'(enable_out), 1);
    chk("dead_exit_rdy", int'(cmd_ready), 1);
    chk("dead_exit_dir", int'(direction), 1);
    for (int k = 1; k <= 8; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("ccw_up_%0d", k), int'(duty_cycle), 64 * k);
    end
    chk("ccw_busy_done", int'(busy), 0);

    // Saturation: -4096 -> target 4095, last steps 4032 then 4095
    cmd = 13'h1000;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sat_1", int'(duty_cycle), 576);
    for (int k = 2; k <= 56; k++) begin
      repeat (4) @(negedge clk);
      e = 512 + 64 * k;
      if (e > 4095) e = 4095;
      chk($sformatf("sat_%0d", k), int'(duty_cycle), e);
    end
    repeat (8) @(negedge clk);
    chk("sat_hold", int'(duty_cycle), 4095);
    chk("sat_dir", int'(direction), 1);
    chk("sat_busy", int'(busy), 0);

    // Dropping enable_in from full scale
    enable_in = 1'b0;
    @(negedge clk);
    chk("stop_full_duty", int'(duty_cycle), 0);
    chk("stop_full_en", int'(enable_out), 0);
    chk("stop_full_dir", int'(direction), 1);
    chk("stop_full_rdy", int'(cmd_ready), 1);
    chk("stop_full_busy", int'(busy), 0);

    // Stop mid-ramp at 320
    enable_in = 1'b1;
    cmd = 13'h1C00;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("stop_run_en", int'(enable_out), 1);
    chk("stop_run_dir", int'(direction), 1);
    for (int k = 1; k <= 5; k++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("stop_ramp_%0d", k), int'(duty_cycle), 64 * k);
    end
    enable_in = 1'b0;
    @(negedge clk);
    chk("stop_mid_duty", int'(duty_cycle), 0);
    chk("stop_mid_en", int'(enable_out), 0);
    chk("stop_mid_dir", int'(direction), 1);
    chk("stop_mid_busy", int'(busy), 0);

    // Commands ignored while enable_in is low
    cmd = 13'd100;
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    chk("ignore_en", int'(enable_out), 0);
    chk("ignore_dir", int'(direction), 1);
    chk("ignore_duty", int'(duty_cycle), 0);

`ifdef MOTOR_CMD_WATCHDOG_EN
    enable_in = 1'b1;
    cmd = 13'd256;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wd_clear", int'(wdog_trip), 0);
    n = 0;
    while (!wdog_trip && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wd_time", n, 100);
    chk("wd_duty_at_trip", int'(duty_cycle), 256);
    n = 0;
    while (enable_out && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wd_idle_reached", int'(n < 100), 1);
    chk("wd_idle_duty", int'(duty_cycle), 0);
    chk("wd_sticky", int'(wdog_trip), 1);
    cmd = 13'd64;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wd_cleared_by_accept", int'(wdog_trip), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/motor_cmd_ramp.md
Name: motor_cmd_ramp

Overview:
Slew-rate limiter and direction sequencer that sits directly upstream of the motor PWM stage. It accepts signed speed commands over a valid/ready handshake and produces the PWM stage's duty_cycle, direction and enable inputs. Magnitude ramps in fixed steps. Direction reversals always pass through zero duty plus a dead-time with the driver disabled, so the H-bridge is never reversed under load.

Parameters:
COUNTER_W, 12, duty resolution; must match the PWM stage's COUNTER_W.
STEP, 64, duty increment/decrement per ramp tick, 1..2^COUNTER_W-1.
RAMP_DIV, 2500, clocks per ramp tick, >=1.
DEAD_CYCLES, 50000, clocks with enable_out=0 during a reversal, >=1.
TIMEOUT, 5_000_000, watchdog clocks (used only with the optional feature).

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
cmd  in  COUNTER_W+1  signed two's-complement speed command; >=0 means CW, <0 means CCW.
cmd_valid  in  1  cmd is valid this cycle.
cmd_ready  out  1  block accepts cmd this cycle.
enable_in  in  1  master run enable; low forces an immediate stop.
duty_cycle  out  COUNTER_W  to PWM duty_cycle.
direction  out  1  to PWM direction; 0=CW, 1=CCW.
enable_out  out  1  to PWM enable.
busy  out  1  high while the current duty differs from the target or the state is DEAD.

Behaviour:
- Reset (reset=0): duty_cycle=0, direction=0, enable_out=0, cmd_ready=0, busy=0, target=0, prescaler=0, state=IDLE. cmd_ready rises on the first clock after reset is released.
- Accept: a command is accepted when cmd_valid && cmd_ready. The target is registered on that edge.
  - tgt_dir = cmd[MSB].
  - tgt_mag = |cmd|, saturated to 2^COUNTER_W-1 (covers cmd = -2^COUNTER_W).
  - The last accepted command wins, including mid-ramp.
- cmd_ready = 1 in IDLE and RUN; 0 in DEAD and in reset.
- Tick prescaler: counts 0..RAMP_DIV-1 and wraps. tick=1 in the cycle it equals RAMP_DIV-1. The prescaler is cleared in IDLE.
- Step arithmetic: computed at COUNTER_W+1 bits.
  - Up: duty = min(duty+STEP, tgt_mag).
  - Down: duty = max(duty-STEP, floor), where floor = 0 if tgt_dir != direction, else tgt_mag.
  - No wrap-around in either direction.
- FSM:
  - IDLE: enable_out=0, duty=0. Goes to RUN on accepting a nonzero cmd while enable_in=1. direction is loaded with tgt_dir on entry.
  - RUN: enable_out=1. On each tick, step toward the target.
    - If tgt_dir != direction and duty==0: go to DEAD.
    - If tgt_mag==0 and duty==0: go to IDLE.
  - DEAD: enable_out=0, duty=0, count DEAD_CYCLES clocks. On the last count: direction <= tgt_dir, prescaler cleared, go to RUN (or to IDLE if tgt_mag==0).
- enable_in=0 in any state: on the next edge, state=IDLE, duty=0, enable_out=0, target=0. direction holds its value. Commands are ignored while enable_in=0.
- Latency:
  - Accepted cmd to target update: 1 clock.
  - First duty step: at the next tick.
  - IDLE to RUN: enable_out rises 1 clock after acceptance.
  - All outputs are registered.
- Simultaneous tick and accept: the step uses the old target; the new target applies from the next cycle.
- Reset asserted mid-ramp or mid-DEAD: all outputs clear asynchronously.

Optional Feature:
MOTOR_CMD_WATCHDOG_EN.
- Defined: a counter is cleared on every accepted cmd and increments otherwise while in RUN. When it reaches TIMEOUT, the target is forced to 0 and the block ramps down to IDLE normally. A sticky output wdog_trip (1 bit) is set, and cleared by the next accept or by reset.
- Undefined: no counter is instantiated and the wdog_trip port is absent. The target persists indefinitely.

Decomposition:
- Shared package motor_pkg holds:
  - state enum {IDLE, RUN, DEAD};
  - DUTY_MAX = 2^COUNTER_W-1 constant;
  - a saturating-absolute-value function.
- One natural sub-module: ramp_tick (prescaler with sync clear, tick output).

Test Plan:
All scenarios use COUNTER_W=12, STEP=64, RAMP_DIV=4, DEAD_CYCLES=8.
1. Reset: hold reset=0 for 5 clocks -> all outputs 0; cmd_ready=1 one clock after release.
2. Ramp up: cmd=+1024 with enable_in=1 -> enable_out=1 and direction=0; duty rises 64 per 4 clocks and reaches 1024 after 16 ticks; busy then falls.
3. Reversal: at duty 1024, send cmd=-512 -> duty ramps to 0 over 16 ticks; then enable_out=0 and cmd_ready=0 for exactly 8 clocks; direction becomes 1; duty reaches 512 after 8 further ticks.
4. Saturation and clamp: cmd=-4096 -> tgt_mag=4095; duty sequence ends ...,4032,4095 with no overflow.
5. Stop: drop enable_in mid-ramp at duty 320 -> on the next clock duty=0, enable_out=0, state IDLE; direction unchanged.
6. Watchdog (macro defined, TIMEOUT=100): cmd=+256, then no further commands -> after 100 clocks wdog_trip=1, duty ramps 256 to 0, state returns to IDLE.
